trace_arbiter: RTL
==================

Name: trace_arbiter

Overview:
- Round-robin arbiter that shares one debug/trace output port between NUM_SRC routed probe sources.
- Each source is a signal bundle routed in from anywhere in the hierarchy, e.g. a logic-analyzer tap in a leaf module.
- The arbiter grants one source at a time for a burst of up to MAX_BURST beats.
- Output is a registered valid/ready stream tagged with the source id.
- Sits at the top level, next to the trace buffer / debug UART it feeds.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..16).
- DATA_W, 8, beat width in bits.
- MAX_BURST, 4, maximum beats per grant (1..256).
- IDLE_TIMEOUT, 16, cycles without src_valid before a grant is revoked (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- src_valid  input  NUM_SRC  per-source beat valid.
- src_data  input  NUM_SRC*DATA_W  per-source beat; source i occupies bits [i*DATA_W +: DATA_W].
- src_last  input  NUM_SRC  per-source end-of-packet flag, qualified by src_valid.
- src_ready  output  NUM_SRC  per-source accept; at most one bit high in any cycle.
- out_valid  output  1  output beat valid.
- out_data  output  DATA_W  output beat.
- out_src_id  output  $clog2(NUM_SRC)  index of the source that produced the beat.
- out_last  output  1  last beat of the current grant.
- out_ready  input  1  downstream accept.
- busy  output  1  high while the FSM is in XFER.
- timeout_pulse  output  1  one-cycle pulse on grant revoke (tied 0 without the optional feature).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset. All state updates on the rising edge of clk.
- Reset values:
  - out_valid=0, out_data=0, out_src_id=0, out_last=0.
  - src_ready=0, busy=0, timeout_pulse=0.
  - state=IDLE, beat_cnt=0.
  - last_grant=NUM_SRC-1, so source 0 has first priority.
- FSM states: IDLE, XFER.
- IDLE:
  - All src_ready=0.
  - If any src_valid is high, pick the first asserted index searching upward from last_grant+1, mod NUM_SRC.
  - Register the winner in grant_id, clear beat_cnt, go to XFER.
  - Arbitration costs exactly one cycle.
- XFER:
  - src_ready[grant_id] = (~out_valid | out_ready); all other src_ready bits are 0.
  - A beat is accepted when src_valid[grant_id] & src_ready[grant_id].
  - On accept, the output register loads on the next edge:
    - out_data = beat of source grant_id.
    - out_src_id = grant_id.
    - out_valid = 1.
    - out_last = src_last[grant_id] | (beat_cnt==MAX_BURST-1).
  - beat_cnt increments on each accept.
  - The burst ends on an accepted beat that has src_last=1 or beat_cnt==MAX_BURST-1.
  - When both end conditions coincide: a single end event, out_last=1 once.
  - On burst end: last_grant=grant_id, go to IDLE.
- Output register: if out_valid & out_ready and no new load, out_valid clears next cycle. If out_valid & ~out_ready, out_data, out_src_id and out_last are held stable.
- Latency: 1 cycle from source accept to out_valid.
- Throughput: 1 beat/cycle within a burst, plus 1 dead cycle (IDLE) between bursts.
- If src_valid[grant_id] drops mid-burst, the grant is held (no revoke without the optional feature).
- Other sources' src_valid are ignored during XFER.
- Reset mid-operation:
  - Any in-flight output beat is discarded.
  - The next cycle sees all reset values, and the next grant starts the search at source 0.
- busy = (state==XFER).
- NUM_SRC=1: arbitration always picks 0; the dead cycle is still present.

Optional Feature:
- Macro: TRACE_TIMEOUT_EN.
- Defined:
  - An idle counter runs in XFER while src_valid[grant_id]=0, and clears on any cycle that source is valid.
  - On reaching IDLE_TIMEOUT, the FSM goes to IDLE with last_grant=grant_id.
  - timeout_pulse=1 for that cycle. No out_last is emitted for the truncated burst.
- Undefined:
  - Counter logic is absent, timeout_pulse is tied 0, and a granted source holds the port indefinitely.

Test Plan:
- Reset, then src0 presents 3 beats 0x11,0x22,0x33 with last on 0x33, out_ready=1 -> src_ready[0] high from cycle 2; out beats 0x11,0x22,0x33 with out_src_id=0; out_last only on 0x33; busy returns 0.
- All 4 sources valid continuously, no src_last, MAX_BURST=4 -> grant order 0,1,2,3,0; 4 beats each; out_last on every 4th beat; exactly one dead cycle between bursts.
- out_ready held low 5 cycles after the 2nd beat of a src2 burst -> out_data stable, src_ready[2]=0; after release the beats continue in order with no loss or duplicate.
- src1 asserts src_last on the beat where beat_cnt==MAX_BURST-1 -> exactly one out_last and one return to IDLE; next grant goes to src2.
- reset pulsed for 1 cycle mid-burst on src3 -> next cycle out_valid=0, src_ready=0, busy=0; with all sources valid, the next grant is src0.
- With TRACE_TIMEOUT_EN, IDLE_TIMEOUT=16: src1 granted, sends 1 beat, then drops valid while src2 stays valid -> timeout_pulse after 16 idle cycles, no out_last; src2 is granted next.

Source files
------------

// File: rtl/trace_arbiter_if.sv
// Stream bundle between the trace arbiter and its probe sources / trace sink.
// master = arbiter side, slave = sources plus downstream consumer.
interface trace_arbiter_if #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 8
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC-1:0]        src_last;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_src_id;
  logic                      out_last;
  logic                      out_ready;

  modport master (
    input  src_valid, src_data, src_last, out_ready,
    output src_ready, out_valid, out_data, out_src_id, out_last
  );

  modport slave (
    output src_valid, src_data, src_last, out_ready,
    input  src_ready, out_valid, out_data, out_src_id, out_last
  );
endinterface

// File: rtl/trace_arbiter.sv
// Round-robin trace-port arbiter: one source per burst of up to MAX_BURST beats.
// Optional grant revoke on source inactivity is enabled by TRACE_TIMEOUT_EN.
module trace_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_W       = 8,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  trace_arbiter_if.master        bus,
  output logic                   busy,
  output logic                   timeout_pulse
);
  localparam int ID_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d, last_grant_q, last_grant_d, pick_s;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]     out_id_q, out_id_d;
  logic [NUM_SRC-1:0]  src_ready_s;
  logic [DATA_W-1:0]   src_beats_s [NUM_SRC];
  logic                sel_valid_s, sel_last_s, accept_s, burst_end_s, timeout_s;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_beat
    assign src_beats_s[g] = bus.src_data[g*DATA_W +: DATA_W];
  end

  assign sel_valid_s = bus.src_valid[grant_q];
  assign sel_last_s  = bus.src_last[grant_q];

  // Round-robin search: lowest offset above last_grant wins, so iterate downward.
  always_comb begin
    logic [ID_W-1:0] idx_v;
    idx_v  = '0;
    pick_s = last_grant_q;
    for (int i = NUM_SRC; i >= 1; i--) begin
      idx_v  = ID_W'((int'(last_grant_q) + i) % NUM_SRC);
      pick_s = bus.src_valid[idx_v] ? idx_v : pick_s;
    end
  end

  // FSM next state, grant bookkeeping and per-source ready.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    src_ready_s  = '0;
    accept_s     = 1'b0;
    burst_end_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|bus.src_valid) begin
          grant_d    = pick_s;
          beat_cnt_d = '0;
          state_d    = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        src_ready_s[grant_q] = ~out_valid_q | bus.out_ready;
        accept_s    = sel_valid_s & src_ready_s[grant_q];
        burst_end_s = accept_s & (sel_last_s | (beat_cnt_q == LAST_CNT));
        if (burst_end_s) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          beat_cnt_d   = '0;
        end else if (accept_s) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else if (timeout_s) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
          beat_cnt_d   = '0;
        end else begin
          state_d = XFER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output register: load on accept, drain on downstream ready, hold under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      out_data_d  = src_beats_s[grant_q];
      out_id_d    = grant_q;
      out_last_d  = sel_last_s | (beat_cnt_q == LAST_CNT);
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(NUM_SRC - 1);
      beat_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_id_q     <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_id_q     <= out_id_d;
      out_last_q   <= out_last_d;
    end
  end

`ifdef TRACE_TIMEOUT_EN
  localparam int TO_W = $clog2(IDLE_TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            timeout_q;

  // Count consecutive granted-but-silent cycles; fires on the IDLE_TIMEOUT-th one.
  always_comb begin
    idle_cnt_d = '0;
    timeout_s  = 1'b0;
    if ((state_q == XFER) && !sel_valid_s) begin
      timeout_s  = (idle_cnt_q == TO_W'(IDLE_TIMEOUT - 1));
      idle_cnt_d = timeout_s ? '0 : idle_cnt_q + TO_W'(1);
    end else begin
      idle_cnt_d = '0;
    end
  end

  // Idle counter and revoke pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      timeout_q  <= timeout_s;
    end
  end

  assign timeout_pulse = timeout_q;
`else
  assign timeout_s     = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  assign bus.src_ready  = src_ready_s;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_src_id = out_id_q;
  assign bus.out_last   = out_last_q;
  assign busy           = (state_q == XFER);
endmodule
